// File: rtl/wb_load_stage.sv
// rtl/wb_load_stage.sv - writeback stage: retires ALU results, holds loads for the memory response
module wb_load_stage #(
    parameter int REG_W      = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [REG_W-1:0]      in_result,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_byte_off,
    input  logic                  mem_rvalid,
    input  logic [REG_W-1:0]      mem_rdata,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic [REG_W-1:0]      wb_wdata,
    output logic                  busy,
    output logic                  spurious_rsp
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [2:0]            ld_funct3;
    logic [1:0]            ld_off;

    assign in_ready = (state == IDLE);
    assign busy     = (state == WAIT);

    // Byte lanes are picked by the full offset, halfwords by offset[1] only.
    function automatic logic [REG_W-1:0] extract(input logic [2:0] f3,
                                                 input logic [1:0] off,
                                                 input logic [REG_W-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  extract = {{(REG_W-8){b[7]}}, b};
            3'b100:  extract = {{(REG_W-8){1'b0}}, b};
            3'b001:  extract = {{(REG_W-16){h[15]}}, h};
            3'b101:  extract = {{(REG_W-16){1'b0}}, h};
            default: extract = word;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb_we        <= 1'b0;
            wb_waddr     <= '0;
            wb_wdata     <= '0;
            spurious_rsp <= 1'b0;
            ld_rd        <= '0;
            ld_funct3    <= '0;
            ld_off       <= '0;
        end else begin
            wb_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_rvalid)
                        spurious_rsp <= 1'b1;
                    if (in_valid) begin
                        if (in_is_load) begin
                            ld_rd     <= in_rd;
                            ld_funct3 <= in_funct3;
                            ld_off    <= in_byte_off;
                            state     <= WAIT;
                        end else begin
                            wb_we    <= (in_rd != '0);
                            wb_waddr <= in_rd;
                            wb_wdata <= in_result;
                        end
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        wb_we    <= (ld_rd != '0);
                        wb_waddr <= ld_rd;
                        wb_wdata <= extract(ld_funct3, ld_off, mem_rdata);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_load_stage.sv
// tb/tb_wb_load_stage.sv - scoreboard bench for wb_load_stage with a behavioural load model
module tb_wb_load_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic        in_is_load;
    logic [2:0]  in_funct3;
    logic [1:0]  in_byte_off;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        busy;
    logic        spurious_rsp;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    wb_load_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_result(in_result),
        .in_is_load(in_is_load), .in_funct3(in_funct3), .in_byte_off(in_byte_off),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .busy(busy), .spurious_rsp(spurious_rsp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference load result from the ISA rules, using shifts and masks.
    function automatic logic [31:0] model_load(input int f3, input int off, input logic [31:0] word);
        logic [31:0] v;
        case (f3)
            0, 4: begin
                v = (word >> (8 * off)) & 32'hFF;
                if (f3 == 0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            1, 5: begin
                v = (word >> (16 * (off / 2))) & 32'hFFFF;
                if (f3 == 1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst && wb_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {27'd0, wb_waddr}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, e.addr});
                chk("wb_wdata", wb_wdata, e.data);
                chk("wb_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
        exp_t e;
        if (rd != 5'd0) begin
            e.addr = rd; e.data = d; e.cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic issue_alu(input logic [4:0] rd, input logic [31:0] res);
        in_valid = 1'b1; in_is_load = 1'b0; in_rd = rd; in_result = res;
        in_funct3 = 3'($urandom); in_byte_off = 2'($urandom);
        chk("alu_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        push_exp(rd, res);
    endtask

    // lat = cycle (counted after the accept cycle) in which mem_rvalid is pulsed
    task automatic issue_load(input logic [4:0] rd, input int f3, input int off,
                              input logic [31:0] word, input int lat);
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = rd; in_funct3 = 3'(f3);
        in_byte_off = 2'(off); in_result = $urandom;
        chk("load_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            chk("wait_in_ready", {31'd0, in_ready}, 32'd0);
            chk("wait_busy", {31'd0, busy}, 32'd1);
            mem_rvalid = (i == lat);
            mem_rdata  = (i == lat) ? word : $urandom;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
        end
        push_exp(rd, model_load(f3, off, word));
        chk("after_load_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_result = '0; in_is_load = 1'b0;
        in_funct3 = '0; in_byte_off = '0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", {31'd0, wb_we}, 32'd0);
        chk("rst_waddr", {27'd0, wb_waddr}, 32'd0);
        chk("rst_wdata", wb_wdata, 32'd0);
        chk("rst_spurious", {31'd0, spurious_rsp}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue_alu(5'd5, 32'hDEAD_BEEF);
        chk("alu_ready_after", {31'd0, in_ready}, 32'd1);
        issue_alu(5'd1, 32'h1111_1111);
        issue_alu(5'd2, 32'h2222_2222);
        issue_alu(5'd3, 32'h3333_3333);

        issue_load(5'd8, 0, 3, 32'h80FF_0000, 4);
        issue_load(5'd9, 4, 3, 32'h80FF_0000, 4);
        issue_load(5'd10, 1, 2, 32'h8001_1234, 2);
        issue_load(5'd11, 5, 0, 32'h8001_1234, 1);
        issue_load(5'd12, 2, 1, 32'h8001_1234, 3);
        issue_load(5'd13, 1, 3, 32'h8001_1234, 1);
        issue_load(5'd14, 0, 1, 32'h0000_7F00, 2);

        issue_alu(5'd0, 32'hCAFE_F00D);
        issue_load(5'd0, 2, 0, 32'h1234_5678, 5);
        issue_alu(5'd4, 32'h0BAD_CAFE);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0)
                issue_alu(5'($urandom), $urandom);
            else
                issue_load(5'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                           $urandom, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        chk("no_spurious_yet", {31'd0, spurious_rsp}, 32'd0);

        // Reset during WAIT, then a late response
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd7; in_funct3 = 3'd2; in_byte_off = 2'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_we", {31'd0, wb_we}, 32'd0);
        chk("midrst_waddr", {27'd0, wb_waddr}, 32'd0);
        chk("midrst_wdata", wb_wdata, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_spurious", {31'd0, spurious_rsp}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        chk("late_rsp_spurious", {31'd0, spurious_rsp}, 32'd1);
        chk("late_rsp_no_we", {31'd0, wb_we}, 32'd0);
        chk("late_rsp_idle", {31'd0, busy}, 32'd0);
        issue_alu(5'd6, 32'h600D_0006);
        chk("spurious_sticky", {31'd0, spurious_rsp}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
